// File: rtl/corrmag_avg_engine.sv
// corrmag_avg_engine: splits an unsigned magnitude stream into periods of L
// lags, sums 2^K periods lag by lag in an accumulator RAM and emits one
// averaged frame of L words per 2^K periods, with tlast on lag L-1.
// Optional build macro: CORRMAG_AVG_ROUND_EN selects round-half-up on the
// final shift instead of plain truncation.
module corrmag_avg_engine #(
    parameter int         DATA_W        = 32,
    parameter int         MAX_PERIOD    = 1024,
    parameter int         MAX_LOG2      = 13,
    parameter logic [7:0] SR_MODE       = 8'd128,
    parameter logic [7:0] SR_THRESHOLD  = 8'd130,
    parameter logic [7:0] SR_AVG_PARAMS = 8'd131,
    parameter logic [7:0] RB_STATUS     = 8'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              set_stb,
    input  logic [7:0]        set_addr,
    input  logic [31:0]       set_data,
    input  logic [7:0]        rb_addr,
    output logic [63:0]       rb_data,
    input  logic [DATA_W-1:0] i_tdata,
    input  logic              i_tlast,
    input  logic              i_tvalid,
    output logic              i_tready,
    output logic [DATA_W-1:0] o_tdata,
    output logic              o_tlast,
    output logic              o_tvalid,
    input  logic              o_tready
);
    localparam int ACC_W = DATA_W + MAX_LOG2;
    localparam int AW    = $clog2(MAX_PERIOD);
    localparam int CMP_W = (DATA_W > 32) ? DATA_W : 32;
    localparam logic [ACC_W:0] ONE_ACC = 1;

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_ACCUM = 2'd2, S_DUMP = 2'd3} state_t;

    // L below 4 would let a lag be re-read before its previous write lands
    function automatic logic [15:0] clamp_len(input logic [15:0] l);
        if (l < 16'd4) return 16'd4;
        if (l > 16'(MAX_PERIOD)) return 16'(MAX_PERIOD);
        return l;
    endfunction

    function automatic logic [3:0] clamp_k(input logic [3:0] k);
        if (k > 4'(MAX_LOG2)) return 4'(MAX_LOG2);
        return k;
    endfunction

    // Divide the lag sum by 2^K, optionally rounding half up
    function automatic logic [DATA_W-1:0] scale_out(input logic [ACC_W-1:0] sum, input logic [3:0] k);
        logic [ACC_W:0] t;
        t = {1'b0, sum};
`ifdef CORRMAG_AVG_ROUND_EN
        if (k != 4'd0) t = t + (ONE_ACC << (k - 4'd1));
`endif
        t = t >> k;
        return t[DATA_W-1:0];
    endfunction

    logic [2:0]  mode_reg;
    logic [31:0] thr_reg;
    logic [15:0] len_reg;
    logic [3:0]  k_reg;
    logic [31:0] thr_w;
    logic [15:0] len_w;
    logic [3:0]  k_w;
    state_t      state;
    logic [15:0] lag;
    logic [15:0] pass;
    logic [31:0] frame_cnt;

    logic              vld_p0, dump_p0, first_p0, last_p0;
    logic [3:0]        k_p0;
    logic [AW-1:0]     lag_p0;
    logic [DATA_W-1:0] sample_p0;
    logic [ACC_W-1:0]  acc_p0;
    logic [ACC_W-1:0]  sum_p0;
    logic [ACC_W-1:0]  ram [MAX_PERIOD];

    logic mode_enable, mode_gated, mode_one_shot;
    logic active_state, p0_adv, accept, trigger, take;
    logic cur_dump, cur_last;
    logic [15:0] last_pass;
    logic unused_inputs;

    assign mode_enable   = mode_reg[0];
    assign mode_gated    = mode_reg[1];
    assign mode_one_shot = mode_reg[2];
    assign unused_inputs = i_tlast;

    assign last_pass    = (16'd1 << k_w) - 16'd1;
    assign cur_dump     = (pass == last_pass);
    assign cur_last     = (lag == len_w - 16'd1);
    assign active_state = (((state == S_ARMED) || (state == S_ACCUM)) && mode_enable) || (state == S_DUMP);
    // A dump word held in p0 can only move once the output register frees up
    assign p0_adv       = !(vld_p0 && dump_p0) || !o_tvalid || o_tready;
    assign i_tready     = active_state && p0_adv;
    assign accept       = i_tvalid && i_tready;
    assign trigger      = (state == S_ARMED) && (CMP_W'(i_tdata) >= CMP_W'(thr_w));
    assign take         = accept && ((state != S_ARMED) || trigger);
    assign sum_p0       = first_p0 ? ACC_W'(sample_p0) : acc_p0 + ACC_W'(sample_p0);

    // Settings bus register file
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_reg <= '0;
            thr_reg  <= '0;
            len_reg  <= '0;
            k_reg    <= '0;
        end else if (set_stb) begin
            if (set_addr == SR_MODE)       mode_reg <= set_data[2:0];
            if (set_addr == SR_THRESHOLD)  thr_reg  <= set_data;
            if (set_addr == SR_AVG_PARAMS) begin
                len_reg <= set_data[15:0];
                k_reg   <= set_data[19:16];
            end
        end
    end

    // Frame sequencer: lag/pass counters, state, and shadowing of L, K, threshold at frame start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            lag       <= '0;
            pass      <= '0;
            frame_cnt <= '0;
            len_w     <= 16'd4;
            k_w       <= '0;
            thr_w     <= '0;
        end else if ((state == S_ARMED || state == S_ACCUM) && !mode_enable) begin
            state <= S_IDLE;
            lag   <= '0;
            pass  <= '0;
        end else if (state == S_IDLE) begin
            if (mode_enable) begin
                len_w <= clamp_len(len_reg);
                k_w   <= clamp_k(k_reg);
                thr_w <= thr_reg;
                lag   <= '0;
                pass  <= '0;
                if (mode_gated) state <= S_ARMED;
                else            state <= (clamp_k(k_reg) == 4'd0) ? S_DUMP : S_ACCUM;
            end
        end else if (take) begin
            if (!cur_last) begin
                lag <= lag + 16'd1;
                if (state == S_ARMED) state <= cur_dump ? S_DUMP : S_ACCUM;
            end else begin
                lag <= '0;
                if (cur_dump) begin
                    pass      <= '0;
                    frame_cnt <= frame_cnt + 32'd1;
                    if (!mode_enable) begin
                        state <= S_IDLE;
                    end else begin
                        len_w <= clamp_len(len_reg);
                        k_w   <= clamp_k(k_reg);
                        thr_w <= thr_reg;
                        if (mode_one_shot && mode_gated) state <= S_ARMED;
                        else state <= (clamp_k(k_reg) == 4'd0) ? S_DUMP : S_ACCUM;
                    end
                end else begin
                    pass  <= pass + 16'd1;
                    state <= ((pass + 16'd1) == last_pass) ? S_DUMP : S_ACCUM;
                end
            end
        end
    end

    // Stage p0 control: valid and dump flag of the sample whose RAM word is being read
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p0  <= 1'b0;
            dump_p0 <= 1'b0;
        end else if (p0_adv) begin
            vld_p0  <= take;
            dump_p0 <= cur_dump;
        end
    end

    // Stage p0 data: sample and its lag context travel with the RAM read
    always_ff @(posedge clk) begin
        if (p0_adv && take) begin
            sample_p0 <= i_tdata;
            lag_p0    <= lag[AW-1:0];
            k_p0      <= k_w;
            first_p0  <= (pass == 16'd0);
            last_p0   <= cur_last;
        end
    end

    // Accumulator RAM: registered read at accept, write-back of non-final passes from p0
    always_ff @(posedge clk) begin
        if (vld_p0 && !dump_p0) ram[lag_p0] <= sum_p0;
        if (p0_adv && take) acc_p0 <= ram[lag[AW-1:0]];
    end

    // ---- stage p1: final add, scale and output register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_tvalid <= 1'b0;
            o_tlast  <= 1'b0;
            o_tdata  <= '0;
        end else if (!o_tvalid || o_tready) begin
            o_tvalid <= vld_p0 && dump_p0;
            o_tlast  <= vld_p0 && dump_p0 && last_p0;
            if (vld_p0 && dump_p0) o_tdata <= scale_out(sum_p0, k_p0);
        end
    end

    // Status readback straight from the live registers
    always_comb begin
        rb_data = '0;
        if (rb_addr == RB_STATUS) rb_data = {frame_cnt, pass, lag[11:0], 2'b00, state};
    end
endmodule

// File: tb/tb_corrmag_avg_engine.sv
// Bench for corrmag_avg_engine: directed vector table, backpressure and
// asynchronous-reset sequences, and randomized frames against an arithmetic
// reference of the lag-wise average.
module tb_corrmag_avg_engine;
    localparam logic [7:0] A_MODE = 8'd128;
    localparam logic [7:0] A_THR  = 8'd130;
    localparam logic [7:0] A_AVG  = 8'd131;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        set_stb = 1'b0;
    logic [7:0]  set_addr = '0;
    logic [31:0] set_data = '0;
    logic [7:0]  rb_addr = '0;
    logic [63:0] rb_data;
    logic [31:0] i_tdata = '0;
    logic        i_tlast = 1'b0;
    logic        i_tvalid = 1'b0;
    logic        i_tready;
    logic [31:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready = 1'b1;

    int checks = 0;
    int errors = 0;
    int rdy_mode = 0;
    longint cyc = 0;
    logic [31:0] out_d[$];
    bit          out_l[$];
    longint      out_c[$];
    longint      acc_c[$];

    corrmag_avg_engine dut (
        .clk(clk), .rst(rst), .set_stb(set_stb), .set_addr(set_addr), .set_data(set_data),
        .rb_addr(rb_addr), .rb_data(rb_data), .i_tdata(i_tdata), .i_tlast(i_tlast),
        .i_tvalid(i_tvalid), .i_tready(i_tready), .o_tdata(o_tdata), .o_tlast(o_tlast),
        .o_tvalid(o_tvalid), .o_tready(o_tready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: o_tready = 1'b1;
            1: o_tready = ($urandom_range(0, 2) != 0);
            default: o_tready = 1'b0;
        endcase
    end

    always @(negedge clk) begin
        if (o_tvalid && o_tready) begin
            out_d.push_back(o_tdata);
            out_l.push_back(o_tlast);
            out_c.push_back(cyc);
        end
    end

    typedef struct {
        int unsigned len_cfg;
        int unsigned k;
        int unsigned mode;
        int unsigned thr;
        int          n_in;
        int unsigned in_v[16];
        int          n_out;
        int unsigned out_v[8];
        int          l_eff;
        int unsigned fc;
        bit          chk_lat;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_reg(input logic [7:0] a, input logic [31:0] d);
        @(posedge clk); #1;
        set_stb = 1'b1; set_addr = a; set_data = d;
        @(posedge clk); #1;
        set_stb = 1'b0;
    endtask

    task automatic do_reset();
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic clear_q();
        out_d.delete(); out_l.delete(); out_c.delete(); acc_c.delete();
    endtask

    task automatic send(input logic [31:0] v, input bit gaps);
        int n;
        if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
        i_tdata = v;
        i_tvalid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (i_tready) break;
            n++;
            if (n > 60) begin
                checks++; errors++;
                $display("FAIL send_timeout: got no accept for %0d expected accept", v);
                break;
            end
        end
        acc_c.push_back(cyc);
        @(posedge clk); #1;
        i_tvalid = 1'b0;
    endtask

    task automatic wait_out(input int want, input int bound);
        int n = 0;
        while (out_d.size() < want && n < bound) begin @(posedge clk); n++; end
        repeat (6) @(posedge clk);
    endtask

    function automatic longint unsigned avg_ref(input longint unsigned sum, input int k);
`ifdef CORRMAG_AVG_ROUND_EN
        if (k > 0) sum = sum + (64'd1 << (k - 1));
`endif
        return (sum >> k) & 64'hFFFF_FFFF;
    endfunction

    task automatic run_row(input int r, input bit skip_reset);
        if (!skip_reset) do_reset();
        clear_q();
        set_reg(A_AVG, {12'd0, 4'(tbl[r].k), 16'(tbl[r].len_cfg)});
        set_reg(A_THR, tbl[r].thr);
        set_reg(A_MODE, tbl[r].mode);
        for (int i = 0; i < tbl[r].n_in; i++) send(tbl[r].in_v[i], 1'b0);
        wait_out(tbl[r].n_out, 100);
        chk($sformatf("row%0d_count", r), out_d.size(), tbl[r].n_out);
        for (int i = 0; i < tbl[r].n_out; i++) begin
            if (i < out_d.size()) begin
                chk($sformatf("row%0d_data%0d", r, i), out_d[i], tbl[r].out_v[i]);
                chk($sformatf("row%0d_last%0d", r, i), out_l[i], ((i + 1) % tbl[r].l_eff) == 0);
                if (tbl[r].chk_lat && i < acc_c.size())
                    chk($sformatf("row%0d_latency%0d", r, i), out_c[i] - acc_c[i], 2);
            end
        end
        rb_addr = 8'd0; #1;
        chk($sformatf("row%0d_frame_cnt", r), rb_data[63:32], tbl[r].fc);
        set_reg(A_MODE, 32'd0);
    endtask

    task automatic run_random(input int iter);
        int l, k, nf, total;
        logic [31:0] s[$];
        longint unsigned sum;
        int idx;
        do_reset();
        clear_q();
        l = $urandom_range(4, 7);
        k = $urandom_range(0, 3);
        nf = 2;
        total = nf * (1 << k) * l;
        set_reg(A_AVG, {12'd0, 4'(k), 16'(l)});
        set_reg(A_MODE, 32'd1);
        rdy_mode = 1;
        for (int i = 0; i < total; i++) s.push_back((i % 5 == 0) ? 32'hFFFF_FFFF : $urandom);
        for (int i = 0; i < total; i++) send(s[i], 1'b1);
        wait_out(nf * l, 400);
        rdy_mode = 0;
        chk($sformatf("rand%0d_count", iter), out_d.size(), nf * l);
        for (int f = 0; f < nf; f++) begin
            for (int j = 0; j < l; j++) begin
                sum = 0;
                for (int p = 0; p < (1 << k); p++) sum += s[(f * (1 << k) + p) * l + j];
                idx = f * l + j;
                if (idx < out_d.size()) begin
                    chk($sformatf("rand%0d_data%0d", iter, idx), out_d[idx], avg_ref(sum, k));
                    chk($sformatf("rand%0d_last%0d", iter, idx), out_l[idx], j == l - 1);
                end
            end
        end
        set_reg(A_MODE, 32'd0);
        rb_addr = 8'd0; #1;
        chk($sformatf("rand%0d_frame_cnt", iter), rb_data[63:32], nf);
    endtask

    initial begin
        tbl[0] = '{len_cfg: 4, k: 1, mode: 1, thr: 0, n_in: 8,
                   in_v: '{10, 20, 30, 40, 12, 22, 32, 42, 0, 0, 0, 0, 0, 0, 0, 0},
                   n_out: 4, out_v: '{11, 21, 31, 41, 0, 0, 0, 0}, l_eff: 4, fc: 1, chk_lat: 0};
        tbl[1] = '{len_cfg: 4, k: 0, mode: 1, thr: 0, n_in: 4,
                   in_v: '{5, 6, 7, 8, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                   n_out: 4, out_v: '{5, 6, 7, 8, 0, 0, 0, 0}, l_eff: 4, fc: 1, chk_lat: 1};
        tbl[2] = '{len_cfg: 4, k: 0, mode: 3, thr: 100, n_in: 6,
                   in_v: '{5, 7, 150, 1, 2, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                   n_out: 4, out_v: '{150, 1, 2, 3, 0, 0, 0, 0}, l_eff: 4, fc: 1, chk_lat: 0};
`ifdef CORRMAG_AVG_ROUND_EN
        tbl[3] = '{len_cfg: 4, k: 2, mode: 1, thr: 0, n_in: 16,
                   in_v: '{1, 4, 0, 3, 2, 4, 0, 3, 2, 4, 0, 3, 1, 4, 1, 3},
                   n_out: 4, out_v: '{2, 4, 0, 3, 0, 0, 0, 0}, l_eff: 4, fc: 1, chk_lat: 0};
`else
        tbl[3] = '{len_cfg: 4, k: 2, mode: 1, thr: 0, n_in: 16,
                   in_v: '{1, 4, 0, 3, 2, 4, 0, 3, 2, 4, 0, 3, 1, 4, 1, 3},
                   n_out: 4, out_v: '{1, 4, 0, 3, 0, 0, 0, 0}, l_eff: 4, fc: 1, chk_lat: 0};
`endif
        tbl[4] = '{len_cfg: 1, k: 0, mode: 1, thr: 0, n_in: 4,
                   in_v: '{9, 8, 7, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0},
                   n_out: 4, out_v: '{9, 8, 7, 6, 0, 0, 0, 0}, l_eff: 4, fc: 1, chk_lat: 0};
        tbl[5] = '{len_cfg: 4, k: 0, mode: 7, thr: 50, n_in: 10,
                   in_v: '{60, 1, 2, 3, 4, 5, 70, 8, 9, 10, 0, 0, 0, 0, 0, 0},
                   n_out: 8, out_v: '{60, 1, 2, 3, 70, 8, 9, 10}, l_eff: 4, fc: 2, chk_lat: 0};

        // reset state
        #2;
        chk("rst_o_tvalid", o_tvalid, 0);
        chk("rst_o_tlast", o_tlast, 0);
        chk("rst_o_tdata", o_tdata, 0);
        chk("rst_i_tready", i_tready, 0);
        chk("rst_status", rb_data, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("idle_i_tready", i_tready, 0);

        for (int r = 0; r < 6; r++) run_row(r, 1'b0);

        // backpressure mid-DUMP
        do_reset();
        clear_q();
        set_reg(A_AVG, {12'd0, 4'd1, 16'd4});
        set_reg(A_MODE, 32'd1);
        fork
            begin
                for (int i = 0; i < 8; i++) send(tbl[0].in_v[i], 1'b0);
            end
            begin
                int n = 0;
                do begin @(negedge clk); n++; end while (!o_tvalid && n < 60);
                rdy_mode = 2;
                @(posedge clk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk($sformatf("stall_i_tready%0d", i), i_tready, 0);
                    chk($sformatf("stall_o_tvalid%0d", i), o_tvalid, 1);
                end
                rdy_mode = 0;
            end
        join
        wait_out(4, 100);
        chk("bp_count", out_d.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < out_d.size()) begin
                chk($sformatf("bp_data%0d", i), out_d[i], tbl[0].out_v[i]);
                chk($sformatf("bp_last%0d", i), out_l[i], i == 3);
            end
        end
        set_reg(A_MODE, 32'd0);

        // asynchronous reset while a DUMP word is held
        do_reset();
        clear_q();
        rdy_mode = 2;
        set_reg(A_AVG, {12'd0, 4'd1, 16'd4});
        set_reg(A_MODE, 32'd1);
        for (int i = 0; i < 5; i++) send(tbl[0].in_v[i], 1'b0);
        begin
            int n = 0;
            do begin @(negedge clk); n++; end while (!o_tvalid && n < 20);
        end
        chk("pre_rst_o_tvalid", o_tvalid, 1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_o_tvalid", o_tvalid, 0);
        chk("async_rst_o_tlast", o_tlast, 0);
        chk("async_rst_status", rb_data, 0);
        chk("async_rst_i_tready", i_tready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        rdy_mode = 0;
        run_row(0, 1'b1);

        for (int it = 0; it < 3; it++) run_random(it);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
